// File: rtl/ps2_kbd_rx_pkg.sv
// Shared definitions for the PS/2 keyboard receiver: FSM states, frame constants, scancodes.
package ps2_kbd_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RX    = 2'd1,
    ST_CHECK = 2'd2
  } ps2_state_e;

  localparam int FRAME_BITS = 11;

  localparam logic [7:0] PS2_BREAK_CODE = 8'hF0;
  localparam logic [7:0] PS2_EXT_CODE   = 8'hE0;

  // Data plus parity must hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [8:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/ps2_fifo.sv
// Synchronous FIFO with a registered head byte that holds its last value when empty.
module ps2_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [W-1:0]  head_q, head_d;
  logic          do_push, do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = head_q;

  always_comb begin
    do_pop   = pop && !empty;
    // A full FIFO still accepts a byte when a pop frees a slot in the same cycle.
    do_push  = push && (!full || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
    head_d   = head_q;
    if (count_d != '0) begin
      head_d = (do_push && (wr_ptr_q == rd_ptr_d)) ? din : mem[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: pin conditioning, frame FSM and scancode FIFO for VIA1.
// Define PS2_BREAK_FILTER_EN to drop break codes (F0) and the byte that follows them.
module ps2_kbd_rx
  import ps2_kbd_rx_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000,
  localparam int CW            = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          fst_clk,
  input  logic          res_n,
  input  logic          ps2_clk,
  input  logic          ps2_dat,
  input  logic          kbd_ack,
  input  logic          err_clr,
  output logic [7:0]    kbd_data,
  output logic          kbd_valid,
  output logic          kbd_err,
  output logic          kbd_ovf,
  output logic [CW-1:0] kbd_count
);

  localparam int FLW = $clog2(FILTER_LEN + 1);
  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]     clk_sync_q, clk_sync_d;
  logic [1:0]     dat_sync_q, dat_sync_d;
  logic           filt_clk_q, filt_clk_d;
  logic [FLW-1:0] filt_cnt_q, filt_cnt_d;
  logic           ack_q, ack_d;
  ps2_state_e     state_q, state_d;
  logic [3:0]     bit_cnt_q, bit_cnt_d;
  logic [9:0]     shift_q, shift_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic           err_q, err_d;
  logic           ovf_q, ovf_d;
`ifdef PS2_BREAK_FILTER_EN
  logic           break_pend_q, break_pend_d;
`endif

  logic           fall, dat_s, pop_req, frame_ok;
  logic           fifo_push, fifo_full, fifo_empty, err_set, ovf_set;
  logic [7:0]     rx_byte;

  assign dat_s    = dat_sync_q[1];
  assign rx_byte  = shift_q[7:0];
  assign frame_ok = odd_parity_ok(shift_q[8:0]) && shift_q[9];

  // Input conditioning and clock filter.
  always_comb begin
    clk_sync_d = {clk_sync_q[0], ps2_clk};
    dat_sync_d = {dat_sync_q[0], ps2_dat};
    ack_d      = kbd_ack;
    pop_req    = kbd_ack && !ack_q;
    filt_clk_d = filt_clk_q;
    filt_cnt_d = '0;
    if (clk_sync_q[1] != filt_clk_q) begin
      if (filt_cnt_q == FLW'(FILTER_LEN - 1)) begin
        filt_clk_d = clk_sync_q[1];
      end else begin
        filt_cnt_d = filt_cnt_q + FLW'(1);
      end
    end
    fall = filt_clk_q && !filt_clk_d;
  end

  // Frame FSM and sticky flags.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    tmo_d     = tmo_q;
    fifo_push = 1'b0;
    err_set   = 1'b0;
`ifdef PS2_BREAK_FILTER_EN
    break_pend_d = break_pend_q;
`endif
    case (state_q)
      ST_IDLE: begin
        tmo_d = '0;
        if (fall && !dat_s) begin
          state_d   = ST_RX;
          bit_cnt_d = '0;
        end
      end
      ST_RX: begin
        if (fall) begin
          shift_d = {dat_s, shift_q[9:1]};
          tmo_d   = '0;
          if (bit_cnt_q == 4'(FRAME_BITS - 2)) begin
            state_d = ST_CHECK;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          state_d = ST_IDLE;
          err_set = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      ST_CHECK: begin
        state_d = ST_IDLE;
        if (frame_ok) begin
`ifdef PS2_BREAK_FILTER_EN
          if (rx_byte == PS2_BREAK_CODE) begin
            break_pend_d = 1'b1;
          end else if (break_pend_q && (rx_byte != PS2_EXT_CODE)) begin
            break_pend_d = 1'b0;
          end else begin
            fifo_push = 1'b1;
          end
`else
          fifo_push = 1'b1;
`endif
        end else begin
          err_set = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
`ifdef PS2_BREAK_FILTER_EN
    if (err_set) begin
      break_pend_d = 1'b0;
    end
`endif
    // A full FIFO only drops the byte when no pop makes room this cycle.
    ovf_set = fifo_push && fifo_full && !pop_req;
    err_d   = err_set || (err_q && !err_clr);
    ovf_d   = ovf_set || (ovf_q && !err_clr);
  end

  always_ff @(posedge fst_clk or negedge res_n) begin
    if (!res_n) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      filt_clk_q <= 1'b1;
      filt_cnt_q <= '0;
      ack_q      <= 1'b0;
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      tmo_q      <= '0;
      err_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      clk_sync_q <= clk_sync_d;
      dat_sync_q <= dat_sync_d;
      filt_clk_q <= filt_clk_d;
      filt_cnt_q <= filt_cnt_d;
      ack_q      <= ack_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tmo_q      <= tmo_d;
      err_q      <= err_d;
      ovf_q      <= ovf_d;
    end
  end

`ifdef PS2_BREAK_FILTER_EN
  always_ff @(posedge fst_clk or negedge res_n) begin
    if (!res_n) begin
      break_pend_q <= 1'b0;
    end else begin
      break_pend_q <= break_pend_d;
    end
  end
`endif

  ps2_fifo #(
    .W     (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (fst_clk),
    .rst_n (res_n),
    .push  (fifo_push),
    .din   (rx_byte),
    .pop   (pop_req),
    .dout  (kbd_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (kbd_count)
  );

  assign kbd_valid = !fifo_empty;
  assign kbd_err   = err_q;
  assign kbd_ovf   = ovf_q;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Scoreboard bench for ps2_kbd_rx: frame-level reference model feeds an expected-byte queue.
module tb_ps2_kbd_rx;

  localparam int DEPTH = 8;
  localparam int FLEN  = 8;
  localparam int TMO   = 2000;
  localparam int HALF  = 20;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          fst_clk = 1'b0;
  logic          res_n   = 1'b0;
  logic          ps2_clk = 1'b1;
  logic          ps2_dat = 1'b1;
  logic          kbd_ack = 1'b0;
  logic          err_clr = 1'b0;
  logic [7:0]    kbd_data;
  logic          kbd_valid, kbd_err, kbd_ovf;
  logic [CW-1:0] kbd_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q[$];
  bit exp_err  = 1'b0;
  bit exp_ovf  = 1'b0;
  bit auto_ack = 1'b0;
`ifdef PS2_BREAK_FILTER_EN
  bit break_pend = 1'b0;
`endif

  always #5 fst_clk = ~fst_clk;

  ps2_kbd_rx #(
    .FIFO_DEPTH     (DEPTH),
    .FILTER_LEN     (FLEN),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .fst_clk   (fst_clk),
    .res_n     (res_n),
    .ps2_clk   (ps2_clk),
    .ps2_dat   (ps2_dat),
    .kbd_ack   (kbd_ack),
    .err_clr   (err_clr),
    .kbd_data  (kbd_data),
    .kbd_valid (kbd_valid),
    .kbd_err   (kbd_err),
    .kbd_ovf   (kbd_ovf),
    .kbd_count (kbd_count)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  // Reference behaviour for one complete frame.
  function automatic void model_frame(input logic [7:0] b, input bit good);
    if (!good) begin
      exp_err = 1'b1;
`ifdef PS2_BREAK_FILTER_EN
      break_pend = 1'b0;
`endif
      return;
    end
`ifdef PS2_BREAK_FILTER_EN
    if (b == 8'hF0) begin
      break_pend = 1'b1;
      return;
    end
    if (break_pend && b != 8'hE0) begin
      break_pend = 1'b0;
      return;
    end
`endif
    if (exp_q.size() < DEPTH) exp_q.push_back(b);
    else exp_ovf = 1'b1;
  endfunction

  task automatic ps2_bit(input bit v);
    @(negedge fst_clk);
    ps2_dat = v;
    repeat (HALF) @(negedge fst_clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge fst_clk);
    ps2_clk = 1'b1;
  endtask

  // nbits < 11 sends a truncated frame that the model does not see.
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int nbits);
    logic [10:0] bits;
    logic par;
    par  = (~^b) ^ bad_par;
    bits = {~bad_stop, par, b, 1'b0};
    if (nbits == 11) model_frame(b, !bad_par && !bad_stop);
    for (int i = 0; i < nbits; i++) ps2_bit(bits[i]);
    @(negedge fst_clk);
    ps2_dat = 1'b1;
    repeat (HALF) @(negedge fst_clk);
  endtask

  task automatic settle();
    repeat (60) @(negedge fst_clk);
  endtask

  task automatic pulse_clr();
    @(negedge fst_clk);
    err_clr = 1'b1;
    @(negedge fst_clk);
    err_clr = 1'b0;
    exp_err = 1'b0;
    exp_ovf = 1'b0;
    @(negedge fst_clk);
  endtask

  task automatic wait_drain();
    auto_ack = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (exp_q.size() == 0 && !kbd_valid) break;
      @(negedge fst_clk);
    end
    repeat (4) @(negedge fst_clk);
    check("drain_queue", exp_q.size(), 0);
    check("drain_count", kbd_count, 0);
  endtask

  // Monitor: acknowledges presented bytes and compares them against the scoreboard.
  initial begin : monitor
    logic [7:0] e;
    forever begin
      @(negedge fst_clk);
      if (auto_ack && res_n && kbd_valid && !kbd_ack) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL pop_unexpected: got 0x%0h expected no byte", kbd_data);
        end else begin
          e = exp_q.pop_front();
          check("pop_data", kbd_data, e);
        end
        kbd_ack = 1'b1;
        @(negedge fst_clk);
        kbd_ack = 1'b0;
        repeat (2) @(negedge fst_clk);
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [7:0] b;
    bit bp, bs;

    repeat (5) @(negedge fst_clk);
    res_n = 1'b1;
    repeat (5) @(negedge fst_clk);
    check("rst_valid", kbd_valid, 0);
    check("rst_count", kbd_count, 0);
    check("rst_err", kbd_err, 0);
    check("rst_ovf", kbd_ovf, 0);
    check("rst_data", kbd_data, 0);

    // Basic byte
    auto_ack = 1'b0;
    send_frame(8'h1C, 1'b0, 1'b0, 11);
    settle();
    check("basic_count", kbd_count, exp_q.size());
    check("basic_valid", kbd_valid, 1);
    check("basic_data", kbd_data, 8'h1C);
    wait_drain();
    check("basic_valid_after_ack", kbd_valid, 0);

    // Parity error
    send_frame(8'h1C, 1'b1, 1'b0, 11);
    settle();
    check("parity_err", kbd_err, exp_err);
    check("parity_count", kbd_count, 0);
    pulse_clr();
    check("parity_err_clr", kbd_err, 0);

    // Overflow
    auto_ack = 1'b0;
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b0, 11);
    settle();
    check("ovf_count", kbd_count, exp_q.size());
    check("ovf_flag", kbd_ovf, exp_ovf);
    wait_drain();
    pulse_clr();
    check("ovf_clr", kbd_ovf, 0);

    // Timeout after start plus four data bits
    send_frame(8'($urandom), 1'b0, 1'b0, 5);
    repeat (TMO - 100) @(negedge fst_clk);
    check("tmo_err_early", kbd_err, 0);
    repeat (110) @(negedge fst_clk);
    exp_err = 1'b1;
`ifdef PS2_BREAK_FILTER_EN
    break_pend = 1'b0;
`endif
    check("tmo_err", kbd_err, exp_err);
    check("tmo_count", kbd_count, 0);
    pulse_clr();
    send_frame(8'h5A, 1'b0, 1'b0, 11);
    settle();
    wait_drain();
    check("tmo_next_err", kbd_err, exp_err);

    // Glitch shorter than the filter, with data low
    @(negedge fst_clk);
    ps2_dat = 1'b0;
    ps2_clk = 1'b0;
    repeat (FLEN - 2) @(negedge fst_clk);
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    repeat (30) @(negedge fst_clk);
    check("glitch_count", kbd_count, 0);
    send_frame(8'h33, 1'b0, 1'b0, 11);
    settle();
    wait_drain();
    check("glitch_err", kbd_err, exp_err);

    // Break code followed by a make code
    auto_ack = 1'b0;
    send_frame(8'hF0, 1'b0, 1'b0, 11);
    send_frame(8'h1C, 1'b0, 1'b0, 11);
    settle();
    check("break_count", kbd_count, exp_q.size());
    wait_drain();

    // Randomized frames with occasional parity/stop errors
    for (int n = 0; n < 16; n++) begin
      b  = 8'($urandom);
      bp = ($urandom_range(0, 4) == 0);
      bs = ($urandom_range(0, 7) == 0);
      auto_ack = ($urandom_range(0, 3) != 0);
      send_frame(b, bp, bs, 11);
      settle();
      $display("frame 0x%02h bad_par=%0d bad_stop=%0d", b, bp, bs);
      check("rand_err", kbd_err, exp_err);
      check("rand_ovf", kbd_ovf, exp_ovf);
      check("rand_count", kbd_count, exp_q.size());
      if (exp_err || exp_ovf) pulse_clr();
    end
    wait_drain();

    // Reset in the middle of a frame with bytes queued and an error pending
    auto_ack = 1'b0;
    send_frame(8'hA1, 1'b0, 1'b0, 11);
    send_frame(8'hB2, 1'b0, 1'b0, 11);
    send_frame(8'h44, 1'b1, 1'b0, 11);
    send_frame(8'h77, 1'b0, 1'b0, 4);
    @(negedge fst_clk);
    res_n = 1'b0;
    exp_q.delete();
    exp_err = 1'b0;
    exp_ovf = 1'b0;
`ifdef PS2_BREAK_FILTER_EN
    break_pend = 1'b0;
`endif
    @(negedge fst_clk);
    check("mid_rst_data", kbd_data, 0);
    check("mid_rst_valid", kbd_valid, 0);
    check("mid_rst_count", kbd_count, 0);
    check("mid_rst_err", kbd_err, exp_err);
    check("mid_rst_ovf", kbd_ovf, exp_ovf);
    repeat (3) @(negedge fst_clk);
    res_n = 1'b1;
    repeat (5) @(negedge fst_clk);
    send_frame(8'h5A, 1'b0, 1'b0, 11);
    settle();
    check("post_rst_count", kbd_count, exp_q.size());
    wait_drain();
    check("post_rst_err", kbd_err, exp_err);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
